raster_line_setup: RTL and testbench

Per-frame and per-line setup generator feeding the rasterizer's edge and barycentric init inputs. It double-buffers one frame's vertex setup from the vertex stage and loads it as the line-0 values during vertical blank. During the horizontal blank of each visible line it serially steps all ten init values by their per-line deltas. Results are stable well before the rasterizer samples them at x==799.

---
 rtl/raster_line_setup.sv | 191 +++++++++++++++++++
 tb/tb_raster_line_setup.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_line_setup.sv
// Per-frame/per-line init generator: shadow capture, vblank commit, serial hblank stepping via one adder.
// Latency: ack 1 cycle after capture, commit 1 cycle, step 10 cycles from x==640; backpressure: none, frame_valid is always accepted.
module raster_line_setup (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [9:0]  x,
    input  logic        [9:0]  y,
    input  logic               frame_valid,
    output logic               frame_ack,
    input  logic signed [19:0] e0_y0_t1,
    input  logic signed [19:0] e1_y0_t1,
    input  logic signed [19:0] e2_y0_t1,
    input  logic signed [19:0] e0_y0_t2,
    input  logic signed [19:0] e1_y0_t2,
    input  logic signed [19:0] e2_y0_t2,
    input  logic signed [19:0] x_screen_v0,
    input  logic signed [19:0] x_screen_v1,
    input  logic signed [19:0] x_screen_v2,
    input  logic signed [19:0] x_screen_v3,
    input  logic signed [21:0] bar_iy_y0,
    input  logic signed [21:0] bar_iz_y0,
    input  logic signed [21:0] bar2_iy_y0,
    input  logic signed [21:0] bar2_iz_y0,
    input  logic signed [21:0] bar_iy_dy,
    input  logic signed [21:0] bar_iz_dy,
    input  logic signed [21:0] bar2_iy_dy,
    input  logic signed [21:0] bar2_iz_dy,
    output logic signed [19:0] e0_init_t1,
    output logic signed [19:0] e1_init_t1,
    output logic signed [19:0] e2_init_t1,
    output logic signed [19:0] e0_init_t2,
    output logic signed [19:0] e1_init_t2,
    output logic signed [19:0] e2_init_t2,
    output logic signed [21:0] bar_iy,
    output logic signed [21:0] bar_iz,
    output logic signed [21:0] bar2_iy,
    output logic signed [21:0] bar2_iz,
    output logic               setup_busy
);

    typedef enum logic {IDLE, STEP} state_t;

    state_t            state;
    logic        [3:0] idx;

    logic signed [19:0] sh_e   [6];
    logic signed [19:0] sh_xv  [4];
    logic signed [21:0] sh_bar [4];
    logic signed [21:0] sh_dy  [4];

    logic signed [19:0] act_xv [4];
    logic signed [21:0] act_dy [4];

    logic signed [19:0] edge_q [6];
    logic signed [21:0] bar_q  [4];

    logic               commit, trig, sel_bar;
    logic signed [19:0] edge_a, edge_d;
    logic signed [21:0] bar_a, bar_d, add_a, add_b, sum;

    assign commit = (y == 10'd524) && (x == 10'd640);
    assign trig   = (y <= 10'd479) && (x == 10'd640);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ack <= 1'b0;
            for (int k = 0; k < 6; k++) sh_e[k] <= '0;
            for (int k = 0; k < 4; k++) begin
                sh_xv[k]  <= '0;
                sh_bar[k] <= '0;
                sh_dy[k]  <= '0;
            end
        end else begin
            frame_ack <= frame_valid;
            if (frame_valid) begin
                sh_e[0]   <= e0_y0_t1;
                sh_e[1]   <= e1_y0_t1;
                sh_e[2]   <= e2_y0_t1;
                sh_e[3]   <= e0_y0_t2;
                sh_e[4]   <= e1_y0_t2;
                sh_e[5]   <= e2_y0_t2;
                sh_xv[0]  <= x_screen_v0;
                sh_xv[1]  <= x_screen_v1;
                sh_xv[2]  <= x_screen_v2;
                sh_xv[3]  <= x_screen_v3;
                sh_bar[0] <= bar_iy_y0;
                sh_bar[1] <= bar_iz_y0;
                sh_bar[2] <= bar2_iy_y0;
                sh_bar[3] <= bar2_iz_y0;
                sh_dy[0]  <= bar_iy_dy;
                sh_dy[1]  <= bar_iz_dy;
                sh_dy[2]  <= bar2_iy_dy;
                sh_dy[3]  <= bar2_iz_dy;
            end
        end
    end

    // Operand select for the single shared adder; edge deltas derive from active vertex x.
    always_comb begin
        edge_a = '0;
        edge_d = '0;
        bar_a  = '0;
        bar_d  = '0;
        case (idx)
            4'd0: begin edge_a = edge_q[0]; edge_d = act_xv[0] - act_xv[1]; end
            4'd1: begin edge_a = edge_q[1]; edge_d = act_xv[1] - act_xv[2]; end
            4'd2: begin edge_a = edge_q[2]; edge_d = act_xv[2] - act_xv[0]; end
            4'd3: begin edge_a = edge_q[3]; edge_d = act_xv[0] - act_xv[2]; end
            4'd4: begin edge_a = edge_q[4]; edge_d = act_xv[2] - act_xv[3]; end
            4'd5: begin edge_a = edge_q[5]; edge_d = act_xv[3] - act_xv[0]; end
            4'd6: begin bar_a = bar_q[0]; bar_d = act_dy[0]; end
            4'd7: begin bar_a = bar_q[1]; bar_d = act_dy[1]; end
            4'd8: begin bar_a = bar_q[2]; bar_d = act_dy[2]; end
            4'd9: begin bar_a = bar_q[3]; bar_d = act_dy[3]; end
            default: ;
        endcase
    end

    assign sel_bar = (idx >= 4'd6);
    assign add_a   = sel_bar ? bar_a : {{2{edge_a[19]}}, edge_a};
    assign add_b   = sel_bar ? bar_d : {{2{edge_d[19]}}, edge_d};
    assign sum     = add_a + add_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            setup_busy <= 1'b0;
            for (int k = 0; k < 6; k++) edge_q[k] <= '0;
            for (int k = 0; k < 4; k++) begin
                bar_q[k]  <= '0;
                act_xv[k] <= '0;
                act_dy[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state      <= STEP;
                        idx        <= '0;
                        setup_busy <= 1'b1;
                    end
                end
                STEP: begin
                    case (idx)
                        4'd0: edge_q[0] <= sum[19:0];
                        4'd1: edge_q[1] <= sum[19:0];
                        4'd2: edge_q[2] <= sum[19:0];
                        4'd3: edge_q[3] <= sum[19:0];
                        4'd4: edge_q[4] <= sum[19:0];
                        4'd5: edge_q[5] <= sum[19:0];
                        4'd6: bar_q[0]  <= sum;
                        4'd7: bar_q[1]  <= sum;
                        4'd8: bar_q[2]  <= sum;
                        4'd9: bar_q[3]  <= sum;
                        default: ;
                    endcase
                    if (idx == 4'd9) begin
                        state      <= IDLE;
                        idx        <= '0;
                        setup_busy <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Commit reads pre-capture shadow contents; a same-edge capture lands next frame.
            if (commit) begin
                for (int k = 0; k < 6; k++) edge_q[k] <= sh_e[k];
                for (int k = 0; k < 4; k++) begin
                    bar_q[k]  <= sh_bar[k];
                    act_xv[k] <= sh_xv[k];
                    act_dy[k] <= sh_dy[k];
                end
            end
        end
    end

    assign e0_init_t1 = edge_q[0];
    assign e1_init_t1 = edge_q[1];
    assign e2_init_t1 = edge_q[2];
    assign e0_init_t2 = edge_q[3];
    assign e1_init_t2 = edge_q[4];
    assign e2_init_t2 = edge_q[5];
    assign bar_iy     = bar_q[0];
    assign bar_iz     = bar_q[1];
    assign bar2_iy    = bar_q[2];
    assign bar2_iz    = bar_q[3];

endmodule

// File: tb/tb_raster_line_setup.sv
// Bench for raster_line_setup: table vectors plus hand sequences for reset, collision and mid-step reset.
module tb_raster_line_setup;

    typedef struct packed {
        logic [5:0][19:0] e;
        logic [3:0][19:0] xv;
        logic [3:0][21:0] b0;
        logic [3:0][21:0] dy;
        logic [9:0][21:0] exp1;
    } vec_t;

    localparam int NV = 4;

    logic clk, rst_n, frame_valid, frame_ack, setup_busy;
    logic [9:0] x, y;
    logic signed [19:0] e0_y0_t1, e1_y0_t1, e2_y0_t1, e0_y0_t2, e1_y0_t2, e2_y0_t2;
    logic signed [19:0] x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3;
    logic signed [21:0] bar_iy_y0, bar_iz_y0, bar2_iy_y0, bar2_iz_y0;
    logic signed [21:0] bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy;
    logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2;
    logic signed [21:0] bar_iy, bar_iz, bar2_iy, bar2_iz;

    raster_line_setup dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .e0_y0_t1(e0_y0_t1), .e1_y0_t1(e1_y0_t1), .e2_y0_t1(e2_y0_t1),
        .e0_y0_t2(e0_y0_t2), .e1_y0_t2(e1_y0_t2), .e2_y0_t2(e2_y0_t2),
        .x_screen_v0(x_screen_v0), .x_screen_v1(x_screen_v1),
        .x_screen_v2(x_screen_v2), .x_screen_v3(x_screen_v3),
        .bar_iy_y0(bar_iy_y0), .bar_iz_y0(bar_iz_y0), .bar2_iy_y0(bar2_iy_y0), .bar2_iz_y0(bar2_iz_y0),
        .bar_iy_dy(bar_iy_dy), .bar_iz_dy(bar_iz_dy), .bar2_iy_dy(bar2_iy_dy), .bar2_iz_dy(bar2_iz_dy),
        .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
        .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
        .bar_iy(bar_iy), .bar_iz(bar_iz), .bar2_iy(bar2_iy), .bar2_iz(bar2_iz),
        .setup_busy(setup_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          nvec = 0;
    int          nerr = 0;
    int          nline;
    vec_t        v [NV];
    vec_t        shm, cur, col, rv;
    logic [21:0] sbq [$];

    // Closed-form line-start value: start + n*delta, wrapped at destination width.
    function automatic logic [21:0] expv(vec_t r, int nl, int k);
        longint a, d, s;
        a = 0;
        d = 0;
        case (k)
            0: begin a = longint'(r.e[0]); d = longint'(r.xv[0]) - longint'(r.xv[1]); end
            1: begin a = longint'(r.e[1]); d = longint'(r.xv[1]) - longint'(r.xv[2]); end
            2: begin a = longint'(r.e[2]); d = longint'(r.xv[2]) - longint'(r.xv[0]); end
            3: begin a = longint'(r.e[3]); d = longint'(r.xv[0]) - longint'(r.xv[2]); end
            4: begin a = longint'(r.e[4]); d = longint'(r.xv[2]) - longint'(r.xv[3]); end
            5: begin a = longint'(r.e[5]); d = longint'(r.xv[3]) - longint'(r.xv[0]); end
            6: begin a = longint'(r.b0[0]); d = longint'(r.dy[0]); end
            7: begin a = longint'(r.b0[1]); d = longint'(r.dy[1]); end
            8: begin a = longint'(r.b0[2]); d = longint'(r.dy[2]); end
            default: begin a = longint'(r.b0[3]); d = longint'(r.dy[3]); end
        endcase
        s = a + longint'(nl) * d;
        if (k < 6) return {2'b00, s[19:0]};
        return s[21:0];
    endfunction

    function automatic logic [21:0] dut_out(int k);
        case (k)
            0: return {2'b00, e0_init_t1};
            1: return {2'b00, e1_init_t1};
            2: return {2'b00, e2_init_t1};
            3: return {2'b00, e0_init_t2};
            4: return {2'b00, e1_init_t2};
            5: return {2'b00, e2_init_t2};
            6: return bar_iy;
            7: return bar_iz;
            8: return bar2_iy;
            default: return bar2_iz;
        endcase
    endfunction

    task automatic check(input string nm, input logic [21:0] act, input logic [21:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int xv, input int yv);
        x = 10'(xv);
        y = 10'(yv);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input vec_t r);
        e0_y0_t1 = r.e[0];   e1_y0_t1 = r.e[1];   e2_y0_t1 = r.e[2];
        e0_y0_t2 = r.e[3];   e1_y0_t2 = r.e[4];   e2_y0_t2 = r.e[5];
        x_screen_v0 = r.xv[0]; x_screen_v1 = r.xv[1];
        x_screen_v2 = r.xv[2]; x_screen_v3 = r.xv[3];
        bar_iy_y0 = r.b0[0]; bar_iz_y0 = r.b0[1]; bar2_iy_y0 = r.b0[2]; bar2_iz_y0 = r.b0[3];
        bar_iy_dy = r.dy[0]; bar_iz_dy = r.dy[1]; bar2_iy_dy = r.dy[2]; bar2_iz_dy = r.dy[3];
    endtask

    task automatic push_model();
        for (int k = 0; k < 10; k++) sbq.push_back(expv(cur, nline, k));
    endtask

    task automatic check_outputs(input string nm);
        for (int k = 0; k < 10; k++) begin
            logic [21:0] e;
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL %s: scoreboard empty at output %0d", nm, k);
            end else begin
                e = sbq.pop_front();
                check($sformatf("%s_out%0d", nm, k), dut_out(k), e);
            end
        end
    endtask

    task automatic capture(input vec_t r);
        drive_frame(r);
        frame_valid = 1'b1;
        cyc(100, 500);
        shm = r;
        check("capture_ack", 22'(frame_ack), 22'd1);
        frame_valid = 1'b0;
        cyc(101, 500);
        check("ack_drop", 22'(frame_ack), 22'd0);
    endtask

    task automatic commit(input bit cap, input vec_t r);
        if (cap) begin
            drive_frame(r);
            frame_valid = 1'b1;
        end
        cyc(640, 524);
        cur   = shm;
        nline = 0;
        push_model();
        check_outputs("commit");
        if (cap) begin
            shm = r;
            check("commit_ack", 22'(frame_ack), 22'd1);
        end
        frame_valid = 1'b0;
        cyc(641, 524);
    endtask

    task automatic step_line(input int yv);
        if (yv <= 479) nline++;
        push_model();
        for (int xx = 638; xx <= 652; xx++) begin
            cyc(xx, yv);
            check($sformatf("busy_y%0d_x%0d", yv, xx), 22'(setup_busy),
                  (yv <= 479 && xx >= 640 && xx <= 649) ? 22'd1 : 22'd0);
        end
        check_outputs($sformatf("line%0d", yv));
    endtask

    initial begin
        // Vector 0 carries the hand-checked values, including both wrap cases.
        v[0]       = '0;
        v[0].e[0]  = 20'd100;
        v[0].e[1]  = 20'h7FFFF;
        v[0].e[2]  = 20'd5;
        v[0].e[3]  = 20'hFFFFD;
        v[0].e[5]  = 20'd1000;
        v[0].xv[0] = 20'd10;
        v[0].xv[1] = 20'd4;
        v[0].xv[2] = 20'd3;
        v[0].xv[3] = 20'hFFFF9;
        v[0].b0[0] = 22'h012345;
        v[0].b0[1] = 22'h1FFFFF;
        v[0].b0[2] = 22'd7;
        v[0].b0[3] = 22'h3FFFFF;
        v[0].dy[0] = 22'h000400;
        v[0].dy[1] = 22'd1;
        v[0].dy[2] = 22'h3FFFFB;
        v[0].dy[3] = 22'h100000;
        for (int i = 1; i < NV; i++) begin
            v[i] = '0;
            for (int k = 0; k < 6; k++) v[i].e[k] = 20'($urandom);
            for (int k = 0; k < 4; k++) begin
                v[i].xv[k] = 20'($urandom);
                v[i].b0[k] = 22'($urandom);
                v[i].dy[k] = 22'($urandom);
            end
        end
        for (int i = 0; i < NV; i++)
            for (int k = 0; k < 10; k++) v[i].exp1[k] = expv(v[i], 1, k);

        // Reset with random inputs toggling.
        rst_n = 1'b0;
        frame_valid = 1'b1;
        rv = '0;
        for (int k = 0; k < 6; k++) rv.e[k] = 20'($urandom);
        for (int k = 0; k < 4; k++) begin
            rv.xv[k] = 20'($urandom);
            rv.b0[k] = 22'($urandom);
            rv.dy[k] = 22'($urandom);
        end
        drive_frame(rv);
        cyc(640, 0);
        cyc(640, 524);
        cyc(641, 0);
        shm = '0; cur = '0; nline = 0;
        push_model();
        check_outputs("reset");
        check("reset_ack", 22'(frame_ack), 22'd0);
        check("reset_busy", 22'(setup_busy), 22'd0);
        frame_valid = 1'b0;
        rst_n = 1'b1;
        step_line(0);

        for (int i = 0; i < NV; i++) begin
            capture(v[i]);
            commit(1'b0, v[i]);
            if (i == 0) begin
                check("e0_commit_100", {2'b00, e0_init_t1}, 22'd100);
                check("bar_iy_commit", bar_iy, 22'h012345);
            end
            step_line(0);
            for (int k = 0; k < 10; k++)
                check($sformatf("tab%0d_out%0d", i, k), dut_out(k), v[i].exp1[k]);
            if (i == 0) begin
                check("e0_line1_106", {2'b00, e0_init_t1}, 22'd106);
                check("e1_wrap", {2'b00, e1_init_t1}, 22'h080000);
                check("bar_iz_wrap", bar_iz, 22'h200000);
                check("bar_iy_step", bar_iy, 22'h012745);
            end
            step_line(1);
            step_line(2);
            if (i == 0) check("e0_line3_118", {2'b00, e0_init_t1}, 22'd118);
            step_line(480);
        end

        // Frame without frame_valid reuses the last captured setup.
        commit(1'b0, v[0]);
        step_line(0);

        // Capture on the commit edge applies one frame later.
        capture(v[0]);
        commit(1'b0, v[0]);
        col      = v[0];
        col.e[0] = 20'd500;
        commit(1'b1, col);
        check("collision_old_100", {2'b00, e0_init_t1}, 22'd100);
        commit(1'b0, col);
        check("collision_new_500", {2'b00, e0_init_t1}, 22'd500);
        step_line(0);

        // Reset while idx==4 aborts stepping at once.
        for (int xx = 638; xx <= 644; xx++) cyc(xx, 0);
        check("midstep_busy_before", 22'(setup_busy), 22'd1);
        rst_n = 1'b0;
        #1;
        shm = '0; cur = '0; nline = 0;
        push_model();
        check_outputs("midstep_rst");
        check("midstep_busy", 22'(setup_busy), 22'd0);
        #2;
        rst_n = 1'b1;
        commit(1'b0, v[0]);
        step_line(0);
        step_line(1);

        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
